// File: rtl/asp_irq_pkg.sv
// Shared constants and types for the ASP interrupt controller.
package asp_irq_pkg;

  // CSR word offsets
  localparam int unsigned CSR_STATUS = 0;
  localparam int unsigned CSR_ENABLE = 1;
  localparam int unsigned CSR_CLEAR  = 2;
  localparam int unsigned CSR_SET    = 3;
  localparam int unsigned CSR_INFO   = 4;

  // Default line assignment on the ASP board
  localparam int unsigned IRQ_DMA_0  = 0;
  localparam int unsigned IRQ_KERNEL = 1;
  localparam int unsigned IRQ_DMA_1  = 2;

  localparam int unsigned DEF_NUM_IRQ  = 4;
  localparam int unsigned DEF_IRQ_USED = 3;

  // Message channel state
  typedef enum logic [0:0] {
    MSG_IDLE = 1'b0,
    MSG_REQ  = 1'b1
  } msg_state_e;

  // Vector index width, never narrower than one bit
  function automatic int unsigned vec_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/asp_irq_rr_arb.sv
// Combinational round-robin first-set search: lowest request at or above
// the pointer, otherwise the lowest request overall (wrap-around).
module asp_irq_rr_arb
  import asp_irq_pkg::*;
#(
  parameter int unsigned NUM_IRQ = DEF_NUM_IRQ,
  parameter int unsigned VEC_W   = vec_width(NUM_IRQ)
) (
  input  logic [NUM_IRQ-1:0] req_i,
  input  logic [VEC_W-1:0]   ptr_i,
  output logic               valid_o,
  output logic [VEC_W-1:0]   idx_o
);

  logic [NUM_IRQ-1:0] upper_mask;
  logic [NUM_IRQ-1:0] upper_req;
  logic [VEC_W-1:0]   upper_idx;
  logic [VEC_W-1:0]   any_idx;

  // Lines at or above the pointer are searched first
  always_comb begin
    upper_mask = '0;
    for (int i = 0; i < int'(NUM_IRQ); i++) begin
      upper_mask[i] = (VEC_W'(i) >= ptr_i);
    end
  end

  assign upper_req = req_i & upper_mask;

  // Downward scan so the lowest set bit is the last one written
  always_comb begin
    upper_idx = '0;
    any_idx   = '0;
    for (int i = int'(NUM_IRQ) - 1; i >= 0; i--) begin
      if (upper_req[i]) upper_idx = VEC_W'(i);
      if (req_i[i])     any_idx   = VEC_W'(i);
    end
  end

  assign valid_o = |req_i;
  assign idx_o   = (|upper_req) ? upper_idx : any_idx;

endmodule

// File: rtl/asp_irq_ctrl.sv
// Vectored interrupt controller: edge/level lines with sticky pending,
// per-line enable, round-robin message channel and a CSR slave.
module asp_irq_ctrl
  import asp_irq_pkg::*;
#(
  parameter int unsigned          NUM_IRQ    = DEF_NUM_IRQ,
  parameter int unsigned          IRQ_USED   = DEF_IRQ_USED,
  parameter logic [NUM_IRQ-1:0]   EDGE_MODE  = '0,
  parameter int unsigned          CSR_DATA_W = 64,
  parameter int unsigned          CSR_ADDR_W = 3,
  parameter int unsigned          VEC_W      = vec_width(NUM_IRQ)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [NUM_IRQ-1:0]    irq_in,
  input  logic [CSR_ADDR_W-1:0] csr_address,
  input  logic                  csr_write,
  input  logic [CSR_DATA_W-1:0] csr_writedata,
  input  logic                  csr_read,
  output logic [CSR_DATA_W-1:0] csr_readdata,
  output logic                  csr_readdatavalid,
  output logic                  csr_waitrequest,
  output logic                  irq_req,
  output logic [VEC_W-1:0]      irq_vec,
  input  logic                  irq_ack,
  output logic                  irq_any
);

  localparam logic [NUM_IRQ-1:0] USED_MASK =
    NUM_IRQ'((64'(1) << IRQ_USED) - 64'(1));
  localparam logic [CSR_DATA_W-1:0] INFO_WORD =
    CSR_DATA_W'({32'(EDGE_MODE), 8'(IRQ_USED), 8'(NUM_IRQ)});

  localparam logic [CSR_ADDR_W-1:0] A_STATUS = CSR_ADDR_W'(CSR_STATUS);
  localparam logic [CSR_ADDR_W-1:0] A_ENABLE = CSR_ADDR_W'(CSR_ENABLE);
  localparam logic [CSR_ADDR_W-1:0] A_CLEAR  = CSR_ADDR_W'(CSR_CLEAR);
  localparam logic [CSR_ADDR_W-1:0] A_SET    = CSR_ADDR_W'(CSR_SET);
  localparam logic [CSR_ADDR_W-1:0] A_INFO   = CSR_ADDR_W'(CSR_INFO);

  logic [NUM_IRQ-1:0]    irq_q;
  logic [NUM_IRQ-1:0]    pending_q, pending_d;
  logic [NUM_IRQ-1:0]    enable_q, enable_d;
  logic [NUM_IRQ-1:0]    sent_q, sent_d;
  msg_state_e            state_q, state_d;
  logic                  req_q, req_d;
  logic [VEC_W-1:0]      vec_q, vec_d;
  logic [VEC_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic                  any_q;
  logic [CSR_DATA_W-1:0] rdata_q, rdata_d;
  logic                  rvalid_q;

  logic [NUM_IRQ-1:0]    wdata_lines;
  logic [NUM_IRQ-1:0]    hw_set;
  logic [NUM_IRQ-1:0]    set_mask;
  logic [NUM_IRQ-1:0]    clr_mask;
  logic [NUM_IRQ-1:0]    ack_mask;
  logic [NUM_IRQ-1:0]    elig;
  logic                  ack_fire;
  logic                  arb_valid;
  logic [VEC_W-1:0]      arb_idx;
  logic                  unused_wdata;

  assign wdata_lines  = csr_writedata[NUM_IRQ-1:0];
  assign unused_wdata = ^csr_writedata[CSR_DATA_W-1:NUM_IRQ];

  // Hardware trigger: rising edge or level per line, unused lines masked
  assign hw_set   = USED_MASK & ((EDGE_MODE & irq_in & ~irq_q) | (~EDGE_MODE & irq_in));
  assign set_mask = (csr_write && (csr_address == A_SET))   ? wdata_lines : '0;
  assign clr_mask = (csr_write && (csr_address == A_CLEAR)) ? wdata_lines : '0;
  assign ack_mask = ack_fire ? (NUM_IRQ'(1) << vec_q) : '0;

  // Pending/enable/sent next state; sets win over clears, sent follows pending
  always_comb begin
    pending_d = USED_MASK & ((pending_q & ~clr_mask) | hw_set | set_mask);
    enable_d  = enable_q;
    if (csr_write && (csr_address == A_ENABLE)) begin
      enable_d = USED_MASK & wdata_lines;
    end
    sent_d = USED_MASK & (sent_q | ack_mask) & pending_d;
  end

  assign elig = pending_q & enable_q & ~sent_q;

  asp_irq_rr_arb #(
    .NUM_IRQ (NUM_IRQ),
    .VEC_W   (VEC_W)
  ) u_arb (
    .req_i   (elig),
    .ptr_i   (rr_ptr_q),
    .valid_o (arb_valid),
    .idx_o   (arb_idx)
  );

  // Message FSM: pick a line in IDLE, hold request until acknowledged
  always_comb begin
    state_d  = state_q;
    req_d    = req_q;
    vec_d    = vec_q;
    rr_ptr_d = rr_ptr_q;
    ack_fire = 1'b0;
    case (state_q)
      MSG_IDLE: begin
        if (arb_valid) begin
          state_d = MSG_REQ;
          req_d   = 1'b1;
          vec_d   = arb_idx;
        end
      end
      MSG_REQ: begin
        if (irq_ack) begin
          ack_fire = 1'b1;
          state_d  = MSG_IDLE;
          req_d    = 1'b0;
          rr_ptr_d = (32'(vec_q) + 32'd1 >= IRQ_USED) ? '0 : vec_q + VEC_W'(1);
        end
      end
      default: begin
        state_d = MSG_IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  // CSR read mux; value is taken before any same-cycle write lands
  always_comb begin
    rdata_d = '0;
    if (csr_read) begin
      case (csr_address)
        A_STATUS: rdata_d = CSR_DATA_W'(pending_q);
        A_ENABLE: rdata_d = CSR_DATA_W'(enable_q);
        A_INFO:   rdata_d = INFO_WORD;
        default:  rdata_d = '0;
      endcase
    end
  end

  // State registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_q     <= '0;
      pending_q <= '0;
      enable_q  <= '0;
      sent_q    <= '0;
      state_q   <= MSG_IDLE;
      req_q     <= 1'b0;
      vec_q     <= '0;
      rr_ptr_q  <= '0;
      any_q     <= 1'b0;
      rdata_q   <= '0;
      rvalid_q  <= 1'b0;
    end else begin
      irq_q     <= irq_in;
      pending_q <= pending_d;
      enable_q  <= enable_d;
      sent_q    <= sent_d;
      state_q   <= state_d;
      req_q     <= req_d;
      vec_q     <= vec_d;
      rr_ptr_q  <= rr_ptr_d;
      any_q     <= |(pending_q & enable_q);
      rdata_q   <= rdata_d;
      rvalid_q  <= csr_read;
    end
  end

  assign csr_readdata      = rdata_q;
  assign csr_readdatavalid = rvalid_q;
  assign csr_waitrequest   = 1'b0;
  assign irq_req           = req_q;
  assign irq_vec           = vec_q;
  assign irq_any           = any_q;

endmodule

// File: tb/tb_asp_irq_ctrl.sv
// Scoreboard bench for asp_irq_ctrl: a line-level reference model predicts
// read data, messages and per-cycle req/any; a negedge monitor checks them.
module tb_asp_irq_ctrl;

  localparam int N    = 4;
  localparam int USED = 3;
  localparam logic [3:0]  EDGE     = 4'b0101;
  localparam logic [63:0] INFO_EXP = 64'h0000_0000_0005_0304;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [3:0]  irq_in;
  logic [2:0]  csr_address;
  logic        csr_write;
  logic [63:0] csr_writedata;
  logic        csr_read;
  logic [63:0] csr_readdata;
  logic        csr_readdatavalid;
  logic        csr_waitrequest;
  logic        irq_req;
  logic [1:0]  irq_vec;
  logic        irq_ack;
  logic        irq_any;

  asp_irq_ctrl #(
    .NUM_IRQ   (4),
    .IRQ_USED  (3),
    .EDGE_MODE (EDGE)
  ) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .irq_in            (irq_in),
    .csr_address       (csr_address),
    .csr_write         (csr_write),
    .csr_writedata     (csr_writedata),
    .csr_read          (csr_read),
    .csr_readdata      (csr_readdata),
    .csr_readdatavalid (csr_readdatavalid),
    .csr_waitrequest   (csr_waitrequest),
    .irq_req           (irq_req),
    .irq_vec           (irq_vec),
    .irq_ack           (irq_ack),
    .irq_any           (irq_any)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  logic [63:0] rd_q[$];
  int          msg_q[$];
  logic [1:0]  st_q[$];   // {irq_any, irq_req} expected after each edge

  // Reference model state (per line bits, plus message bookkeeping)
  bit [3:0] m_pend, m_en, m_sent, m_in_prev;
  bit       m_busy;
  int       m_vec, m_ptr;

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_pend = '0; m_en = '0; m_sent = '0; m_in_prev = '0;
    m_busy = 1'b0; m_vec = 0; m_ptr = 0;
    rd_q.delete(); msg_q.delete(); st_q.delete();
  endtask

  // Apply the current inputs for one clock: predict, wait the edge, commit
  task automatic tick();
    bit [3:0]    pn, sn, en_n, wd, ev, in_s;
    bit          hw, busy_n, any_e, rd, push_msg;
    int          a, vec_n, ptr_n;
    logic [63:0] rexp;
    ev = EDGE; wd = csr_writedata[3:0]; a = int'(csr_address);
    in_s = irq_in; rd = csr_read; push_msg = 1'b0;
    rexp = '0;
    if (a == 0) rexp = {60'b0, m_pend};
    else if (a == 1) rexp = {60'b0, m_en};
    else if (a == 4) rexp = INFO_EXP;
    for (int i = 0; i < N; i++) begin
      hw = ev[i] ? (in_s[i] && !m_in_prev[i]) : in_s[i];
      pn[i] = m_pend[i];
      if (csr_write && a == 2 && wd[i]) pn[i] = 1'b0;
      if (hw || (csr_write && a == 3 && wd[i])) pn[i] = 1'b1;
      if (i >= USED) pn[i] = 1'b0;
      en_n[i] = (csr_write && a == 1) ? (wd[i] && i < USED) : m_en[i];
    end
    sn = m_sent; busy_n = m_busy; vec_n = m_vec; ptr_n = m_ptr;
    if (m_busy) begin
      if (irq_ack) begin
        sn[m_vec] = 1'b1;
        ptr_n     = (m_vec + 1) % USED;
        busy_n    = 1'b0;
      end
    end else begin
      for (int k = 0; k < N; k++) begin
        int j;
        j = (m_ptr + k) % N;
        if (!busy_n && m_pend[j] && m_en[j] && !m_sent[j]) begin
          busy_n = 1'b1; vec_n = j; push_msg = 1'b1;
        end
      end
    end
    for (int i = 0; i < N; i++) sn[i] = sn[i] && pn[i];
    any_e = ((m_pend & m_en) != 4'b0);
    @(posedge clk);
    if (rd) rd_q.push_back(rexp);
    if (push_msg) msg_q.push_back(vec_n);
    st_q.push_back({any_e, busy_n});
    m_pend = pn; m_en = en_n; m_sent = sn; m_in_prev = in_s;
    m_busy = busy_n; m_vec = vec_n; m_ptr = ptr_n;
    #1;
  endtask

  task automatic csr_wr(input int a, input logic [63:0] d);
    csr_write = 1'b1; csr_address = 3'(a); csr_writedata = d;
    tick();
    csr_write = 1'b0;
  endtask

  task automatic csr_rd(input int a, output logic [63:0] d);
    csr_read = 1'b1; csr_address = 3'(a);
    tick();
    csr_read = 1'b0;
    d = csr_readdata;
  endtask

  // Wait (bounded) for an outstanding message, then acknowledge after dly cycles
  task automatic ack_msg(input int dly);
    int n;
    n = 0;
    while (!m_busy && n < 40) begin tick(); n++; end
    if (!m_busy) begin
      vectors++; miscompares++;
      $display("FAIL ack_msg: no message outstanding after 40 cycles");
    end else begin
      repeat (dly) tick();
      irq_ack = 1'b1;
      tick();
      irq_ack = 1'b0;
    end
  endtask

  // Monitor: checks read data, message vector and per-cycle req/any
  logic req_prev = 1'b0;
  int   held_exp = 0;
  always @(negedge clk) begin
    if (!reset_n) begin
      req_prev = 1'b0;
    end else begin
      if (csr_readdatavalid) begin
        if (rd_q.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL csr_rvalid: unexpected readdatavalid, data 0x%0h", csr_readdata);
        end else begin
          cmp("csr_readdata", csr_readdata, rd_q.pop_front());
        end
      end
      if (st_q.size() > 0) cmp("req_any", {62'b0, irq_any, irq_req}, {62'b0, st_q.pop_front()});
      if (irq_req && !req_prev) begin
        if (msg_q.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL irq_msg: unexpected request vec=%0d, none predicted", irq_vec);
        end else begin
          held_exp = msg_q.pop_front();
          cmp("irq_vec", 64'(irq_vec), 64'(held_exp));
        end
      end
      if (irq_req && irq_ack) cmp("irq_vec_held", 64'(irq_vec), 64'(held_exp));
      req_prev = irq_req;
    end
  end

  initial begin
    logic [63:0] d;
    int          r;
    int          n;
    reset_n = 1'b0; irq_in = 4'b0111; csr_address = '0; csr_write = 1'b0;
    csr_writedata = '0; csr_read = 1'b0; irq_ack = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    cmp("rst_irq_req", 64'(irq_req), 0);
    cmp("rst_irq_vec", 64'(irq_vec), 0);
    cmp("rst_irq_any", 64'(irq_any), 0);
    cmp("rst_rdata", csr_readdata, 0);
    cmp("rst_rvalid", 64'(csr_readdatavalid), 0);
    cmp("waitrequest", 64'(csr_waitrequest), 0);
    reset_n = 1'b1;

    // Lines set with enable=0: visible in STATUS, no request
    tick(); tick();
    csr_rd(0, d); cmp("status_after_reset", d, 64'h7);
    irq_in = 4'b0000; tick();
    csr_wr(2, 64'h7);

    // Edge pulses on lines 0 and 2 in the same cycle, slow acks
    csr_wr(1, 64'h5);
    irq_in = 4'b0101; tick();
    irq_in = 4'b0000; tick();
    ack_msg(5);
    ack_msg(5);
    repeat (3) tick();
    csr_wr(2, 64'h5);

    // Level line 1: no re-request while input high, clear is overridden
    csr_wr(1, 64'h2);
    irq_in = 4'b0010;
    ack_msg(2);
    repeat (3) tick();
    csr_wr(2, 64'h2);
    csr_rd(0, d); cmp("status_level_held", d, 64'h2);
    repeat (4) tick();
    irq_in = 4'b0000; tick();
    csr_wr(2, 64'h2);
    csr_rd(0, d); cmp("status_level_cleared", d, 64'h0);
    irq_in = 4'b0010;
    ack_msg(1);
    irq_in = 4'b0000; tick();
    csr_wr(2, 64'h2);

    // Round robin between lines 0 and 2 re-pended via SET
    csr_wr(1, 64'h5);
    for (int it = 0; it < 2; it++) begin
      csr_wr(3, 64'h5);
      ack_msg(1);
      ack_msg(1);
      tick();
      csr_wr(2, 64'h5);
    end
    csr_wr(3, 64'h8);
    csr_rd(0, d); cmp("status_unused_line", d, 64'h0);

    // CSR corner cases
    csr_rd(4, d); cmp("info", d, INFO_EXP);
    csr_write = 1'b1; csr_writedata = 64'h2;
    csr_rd(1, d); cmp("enable_rw_same_cycle", d, 64'h5);
    csr_write = 1'b0;
    csr_rd(1, d); cmp("enable_after_write", d, 64'h2);
    csr_rd(7, d); cmp("addr7_read", d, 64'h0);

    // Randomised traffic
    for (int c = 0; c < 2500; c++) begin
      if ($urandom_range(0, 99) < 20) irq_in = 4'($urandom_range(0, 15));
      r = $urandom_range(0, 99);
      csr_read = (r < 20);
      csr_write = (r >= 12 && r < 35);
      csr_address = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7))
                                                : 3'($urandom_range(1, 3));
      csr_writedata = {$urandom, $urandom};
      irq_ack = m_busy ? ($urandom_range(0, 99) < 30) : ($urandom_range(0, 99) < 5);
      tick();
    end
    csr_read = 1'b0; csr_write = 1'b0; irq_ack = 1'b0;
    tick(); tick();

    // Reset while a message is outstanding aborts it immediately
    irq_in = 4'b0000;
    csr_wr(2, 64'hF);
    csr_wr(1, 64'h7);
    csr_wr(3, 64'h1);
    n = 0;
    while (!m_busy && n < 40) begin tick(); n++; end
    if (!m_busy) begin
      vectors++; miscompares++;
      $display("FAIL reset_in_req: no message outstanding before reset");
    end
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1 cmp("async_reset_req", 64'(irq_req), 0);
    repeat (2) @(posedge clk);
    model_reset();
    #1 reset_n = 1'b1;
    repeat (5) tick();
    cmp("no_msg_after_reset", 64'(irq_req), 0);
    csr_wr(1, 64'h1);
    csr_wr(3, 64'h1);
    ack_msg(1);
    repeat (3) tick();

    cmp("rd_queue_drained", 64'(rd_q.size()), 0);
    cmp("msg_queue_drained", 64'(msg_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/asp_irq_ctrl.md
Name: asp_irq_ctrl

Overview:
- Parametrised interrupt controller for the ASP board region.
- Aggregates NUM_IRQ interrupt sources, for example DMA_0, kernel and DMA_1, into a single vectored request/acknowledge message channel toward the host interface.
- Each line is configurable as edge or level triggered.
- Provides per-line enable and sticky-pending state, plus a 64-bit CSR slave for software status, enable, clear, set and info access.
- Successor to the fixed three-of-four-line interrupt scheme: generalised in line count and mode, and adds round-robin arbitration and per-line re-request suppression.

Parameters:
- NUM_IRQ, 4, number of interrupt lines (1..32).
- IRQ_USED, 3, lines [IRQ_USED-1:0] are active; higher lines are forced inactive.
- EDGE_MODE, NUM_IRQ'b0, per-line mode: 1 = rising-edge triggered, 0 = level triggered.
- CSR_DATA_W, 64, CSR data width.
- CSR_ADDR_W, 3, CSR word-address width.
- VEC_W, $clog2(NUM_IRQ) (minimum 1), width of the vector index.

Ports:
- clk  in  1  single clock.
- reset_n  in  1  asynchronous, active-low reset.
- irq_in  in  NUM_IRQ  interrupt sources, synchronous to clk.
- csr_address  in  CSR_ADDR_W  word address.
- csr_write  in  1  write strobe.
- csr_writedata  in  CSR_DATA_W  write data.
- csr_read  in  1  read strobe.
- csr_readdata  out  CSR_DATA_W  read data.
- csr_readdatavalid  out  1  read-data qualifier.
- csr_waitrequest  out  1  tied to 0.
- irq_req  out  1  interrupt message request.
- irq_vec  out  VEC_W  index of the line being signalled.
- irq_ack  in  1  message accepted.
- irq_any  out  1  registered OR of (pending & enable).

Behaviour:
- Reset (asynchronous, reset_n low) clears everything:
  - pending=0, enable=0, sent=0, irq_q=0.
  - FSM in IDLE, rr_ptr=0.
  - irq_req=0, irq_vec=0, irq_any=0.
  - csr_readdata=0, csr_readdatavalid=0.
  - Reset mid-message aborts the message with no ack required.
- irq_q registers irq_in each cycle.
  - Edge line set condition: irq_in & ~irq_q.
  - Level line set condition: irq_in.
  - Pending bits are visible the cycle after the triggering sample.
- Pending update order within a cycle: hardware set and SET-CSR set take priority over CLEAR-CSR.
  - A level line whose input is still high re-sets the cycle after a clear; it is not cleared.
- Lines at index >= IRQ_USED: pending, enable and sent are held at 0; writes to those bits are ignored.
- sent[i] clears in the same cycle pending[i] clears.
- CSR map (word addresses):
  - 0 STATUS: RO, pending.
  - 1 ENABLE: RW.
  - 2 CLEAR: W1C pending; reads return 0.
  - 3 SET: W1S pending; reads return 0.
  - 4 INFO: RO, [7:0]=NUM_IRQ, [15:8]=IRQ_USED, [47:16]=EDGE_MODE zero-extended.
  - Other addresses: reads return 0, writes are ignored.
- CSR timing:
  - Read latency is exactly 1 cycle: csr_readdatavalid pulses the cycle after csr_read.
  - A simultaneous read and write to the same register returns the pre-write value.
- Message FSM:
  - IDLE: if elig = pending & enable & ~sent is non-zero, select the first set bit searching upward from rr_ptr with wrap-around. Register irq_vec and assert irq_req next cycle; go to REQ.
  - REQ: irq_req=1 and irq_vec are held stable until irq_ack. The request is never withdrawn, even if the line is cleared or disabled.
  - On ack: sent[irq_vec]=1, rr_ptr=irq_vec+1 (wrapping to 0 at IRQ_USED), irq_req deasserts next cycle, return to IDLE.
  - A line is re-signalled only after software clears it and it sets again.
  - irq_ack while irq_req=0 is ignored.
  - Minimum gap between two messages is 1 idle cycle.
- irq_any is registered: 1-cycle latency from a pending or enable change.

Decomposition:
- Shared package (asp_irq_pkg) holds:
  - CSR word offsets: STATUS/ENABLE/CLEAR/SET/INFO.
  - Default line-index constants: DMA_0=0, KERNEL=1, DMA_1=2.
  - Default NUM_IRQ=4 and IRQ_USED=3.
- One sub-module: asp_irq_rr_arb, a combinational round-robin first-set search over NUM_IRQ with a pointer input, producing a valid flag and an index. Everything else stays in the top.

Test Plan:
- Reset with irq_in=4'b0111 → all outputs 0; after release with enable=0, STATUS reads 0x7 and irq_req stays 0.
- Level line 1, ENABLE=0x2, hold irq_in[1]=1 → irq_req=1, irq_vec=1; ack → no second request; CLEAR 0x2 while input high → STATUS still 0x2 and no new request; drop input, CLEAR → STATUS 0; re-raise → new request vec=1.
- EDGE_MODE=4'b0101, ENABLE=0x5, one-cycle pulses on lines 0 and 2 in the same cycle → two messages in order vec=0 then vec=2, irq_req stable across 5-cycle ack delays.
- Round-robin: lines 0 and 2 repeatedly re-pended via SET after each ack → vec sequence 0, 2, 0, 2; line 3 (unused) SET writes → STATUS bit 3 stays 0.
- CSR: read INFO → 0x0000_0000_0005_0304; read/write ENABLE in the same cycle → old value returned with csr_readdatavalid one cycle later; read address 7 → 0.
- Assert reset_n low while in REQ → irq_req=0 immediately (asynchronously); after release, no message until pending is set again.
